intersection_controller: RTL and testbench
==========================================

INTERSECTION_CONTROLLER -- requirements
Module: intersection_controller

Interface
REQ-001 The block SHALL have parameter N_PHASES, default 4, meaning number of signal phases (legal range 2..8).
REQ-002 The block SHALL have parameter TW, default 8, meaning timer width in bits.
REQ-003 The block SHALL have parameter GREEN_T, default 30, meaning base green length in ticks.
REQ-004 The block SHALL have parameter EXT_T, default 10, meaning one-shot green extension in ticks.
REQ-005 The block SHALL have parameter YELLOW_T, default 3, meaning yellow length in ticks.
REQ-006 The block SHALL have parameter ALLRED_T, default 2, meaning all-red clearance length in ticks.
REQ-007 The block SHALL have port clk, input, width 1: clock, all logic on its rising edge.
REQ-008 The block SHALL have port rst, input, width 1: reset, synchronous, active-high.
REQ-009 The block SHALL have port tick, input, width 1: timing strobe; timers advance only on cycles where tick=1.
REQ-010 The block SHALL have port demand, input, width N_PHASES: per-phase service request (level).
REQ-011 The block SHALL have port ext_req, input, width N_PHASES: per-phase green extension request.
REQ-012 The block SHALL have port force_red, input, width 1: preemption, drive all phases to red and hold.
REQ-013 The block SHALL have port attention, input, width 1: request flashing-yellow mode.
REQ-014 The block SHALL have port green/yellow/red, output, width N_PHASES each: registered lamp drives, one bit per phase.
REQ-015 The block SHALL have port phase, output, width $clog2(N_PHASES): index of the current phase.
REQ-016 The block SHALL have port state, output, width 3: INIT=0, GREEN=1, YELLOW=2, ALLRED=3, FLASH=4.

Function
REQ-017 States: INIT, GREEN, YELLOW, ALLRED, FLASH. A TW-bit timer is cleared to 0 on every state entry; it increments on tick.
REQ-018 INIT SHALL last exactly one clock and then enter GREEN for phase 0.
REQ-019 GREEN: if ext_req[phase]=1 while ext_used=0, the block SHALL set green_len = GREEN_T+EXT_T and ext_used=1; a second request in the same green is ignored. ext_used clears on GREEN entry.
REQ-020 GREEN SHALL exit to YELLOW on the tick cycle where timer == green_len-1.
REQ-021 YELLOW SHALL exit to ALLRED on the tick cycle where timer == YELLOW_T-1.
REQ-022 ALLRED SHALL exit on the tick cycle where timer == ALLRED_T-1. Exit goes to FLASH if attention=1. Otherwise it goes to GREEN of the next phase: the first index after phase, with wrap-around, that has demand set. If no demand bit is set, phase+1 mod N_PHASES.
REQ-023 Priority per cycle SHALL be force_red > attention > timer expiry.
REQ-024 force_red in GREEN SHALL force YELLOW on the next clock. In YELLOW the yellow count completes normally. In ALLRED the timer is held at 0 and no exit occurs while force_red=1.
REQ-025 attention in GREEN SHALL force YELLOW on the next clock. attention SHALL NOT interrupt YELLOW or ALLRED.
REQ-026 FLASH: green=0, red=0, and all yellow bits toggle together on each tick, starting at 1. FLASH SHALL exit to ALLRED (timer 0, phase unchanged) one clock after attention=0. force_red in FLASH SHALL exit to ALLRED on the next clock.
REQ-027 Outside FLASH, the current phase SHALL show exactly one of green/yellow/red matching state (ALLRED/INIT: red). Every other phase SHALL show red only.
REQ-028 Lamp outputs SHALL be registered and reflect the state one clock after the transition.
REQ-029 Parameters SHALL satisfy GREEN_T+EXT_T < 2**TW and YELLOW_T, ALLRED_T, GREEN_T >= 1; an elaboration-time check SHALL flag violations.
REQ-030 The timer SHALL never wrap; expiry comparison is equality, and the timer stops counting at expiry.

Reset
REQ-031 On rst=1 at a clock edge: state=INIT, phase=0, timer=0, ext_used=0, green=0, yellow=0, red=all ones. This applies from any state, mid-operation included.
REQ-032 rst SHALL take priority over all other inputs.

Verification
REQ-033 tick=1 each clock, demand=all ones, N_PHASES=4 -> phase 0 green 30 clocks, yellow 3, all-red 2, then phase 1 green; sequence 0,1,2,3,0.
REQ-034 ext_req[0] pulsed twice during phase 0 green -> green lasts 40 ticks, not 50; next green of phase 0 lasts 30 again.
REQ-035 demand=4'b1000 only -> after phase 0 clearance phase 3 goes green, then phase 3 again after its clearance.
REQ-036 force_red asserted at green tick 10 for 20 clocks -> yellow next clock, 3 yellow, all-red held until release, then 2 more all-red ticks.
REQ-037 attention asserted in green -> yellow, all-red, FLASH with yellow toggling every tick; deassert -> all-red 2 ticks -> next phase green.
REQ-038 rst pulsed mid-yellow of phase 2 -> next clock red=all ones, phase=0, state=INIT, then phase 0 green.

Source files
------------

// File: rtl/intersection_controller.sv
// Signal controller for one intersection: green / yellow / all-red cycling per phase,
// one-shot green extension, red preemption and flashing-yellow attention mode.
module intersection_controller #(
  parameter int N_PHASES = 4,
  parameter int TW       = 8,
  parameter int GREEN_T  = 30,
  parameter int EXT_T    = 10,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic [N_PHASES-1:0]         demand,
  input  logic [N_PHASES-1:0]         ext_req,
  input  logic                        force_red,
  input  logic                        attention,
  output logic [N_PHASES-1:0]         green,
  output logic [N_PHASES-1:0]         yellow,
  output logic [N_PHASES-1:0]         red,
  output logic [$clog2(N_PHASES)-1:0] phase,
  output logic [2:0]                  state
);

  localparam int unsigned PW = $clog2(N_PHASES);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_GREEN  = 3'd1;
  localparam logic [2:0] S_YELLOW = 3'd2;
  localparam logic [2:0] S_ALLRED = 3'd3;
  localparam logic [2:0] S_FLASH  = 3'd4;

  localparam logic [TW-1:0] GREEN_BASE  = TW'(GREEN_T);
  localparam logic [TW-1:0] GREEN_LONG  = TW'(GREEN_T + EXT_T);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] TIMER_MAX   = {TW{1'b1}};

  // Elaboration-time parameter legality
  if (N_PHASES < 2 || N_PHASES > 8) begin : g_bad_n_phases
    $error("intersection_controller: N_PHASES must be in 2..8");
  end
  if ((longint'(GREEN_T) + longint'(EXT_T)) >= (longint'(1) << TW)) begin : g_bad_timer_width
    $error("intersection_controller: GREEN_T+EXT_T must be below 2**TW");
  end
  if (GREEN_T < 1 || YELLOW_T < 1 || ALLRED_T < 1) begin : g_bad_lengths
    $error("intersection_controller: GREEN_T, YELLOW_T and ALLRED_T must be >= 1");
  end

  logic [2:0]          r_state;
  logic [PW-1:0]       r_phase;
  logic [TW-1:0]       r_timer;
  logic [TW-1:0]       r_green_len;
  logic                r_ext_used;
  logic                r_flash;
  logic [N_PHASES-1:0] r_green;
  logic [N_PHASES-1:0] r_yellow;
  logic [N_PHASES-1:0] r_red;

  logic [2:0]            w_state_nxt;
  logic [PW-1:0]         w_phase_nxt;
  logic [TW-1:0]         w_timer_nxt;
  logic [TW-1:0]         w_green_len_nxt;
  logic                  w_ext_used_nxt;
  logic                  w_flash_nxt;
  logic [TW-1:0]         w_green_last;
  logic [2*N_PHASES-1:0] w_demand_dd;
  logic [N_PHASES-1:0]   w_demand_rot;
  logic                  w_found;
  int unsigned           w_off;
  logic [PW-1:0]         w_next_phase;
  logic [N_PHASES-1:0]   w_sel;
  logic [N_PHASES-1:0]   w_green_nxt;
  logic [N_PHASES-1:0]   w_yellow_nxt;
  logic [N_PHASES-1:0]   w_red_nxt;

  assign w_green_last = r_green_len - TW'(1);

  // Demand rotated so bit k is the phase k+1 positions after the current one
  assign w_demand_dd  = {demand, demand};
  assign w_demand_rot = N_PHASES'(w_demand_dd >> (32'(r_phase) + 32'd1));

  always_comb begin
    w_found = 1'b0;
    w_off   = 0;
    for (int k = 0; k < N_PHASES; k++) begin
      if (!w_found && w_demand_rot[k]) begin
        w_found = 1'b1;
        w_off   = k;
      end
    end
    w_next_phase = PW'((32'(r_phase) + 32'd1 + w_off) % 32'(N_PHASES));
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_timer_nxt     = r_timer;
    w_green_len_nxt = r_green_len;
    w_ext_used_nxt  = r_ext_used;
    w_flash_nxt     = r_flash;
    case (r_state)
      S_INIT: begin
        w_state_nxt     = S_GREEN;
        w_phase_nxt     = '0;
        w_timer_nxt     = '0;
        w_green_len_nxt = GREEN_BASE;
        w_ext_used_nxt  = 1'b0;
      end
      S_GREEN: begin
        if (force_red || attention) begin
          w_state_nxt = S_YELLOW;
          w_timer_nxt = '0;
        end else if (tick && r_timer == w_green_last) begin
          w_state_nxt = S_YELLOW;
          w_timer_nxt = '0;
        end else begin
          if (tick) w_timer_nxt = r_timer + TW'(1);
          if (ext_req[r_phase] && !r_ext_used) begin
            w_green_len_nxt = GREEN_LONG;
            w_ext_used_nxt  = 1'b1;
          end
        end
      end
      S_YELLOW: begin
        if (tick && r_timer == YELLOW_LAST) begin
          w_state_nxt = S_ALLRED;
          w_timer_nxt = '0;
        end else if (tick) begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_ALLRED: begin
        if (force_red) begin
          w_timer_nxt = '0;
        end else if (tick && r_timer == ALLRED_LAST) begin
          w_timer_nxt = '0;
          if (attention) begin
            w_state_nxt = S_FLASH;
            w_flash_nxt = 1'b1;
          end else begin
            w_state_nxt     = S_GREEN;
            w_phase_nxt     = w_next_phase;
            w_green_len_nxt = GREEN_BASE;
            w_ext_used_nxt  = 1'b0;
          end
        end else if (tick) begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_FLASH: begin
        if (force_red || !attention) begin
          w_state_nxt = S_ALLRED;
          w_timer_nxt = '0;
        end else if (tick) begin
          w_flash_nxt = ~r_flash;
          if (r_timer != TIMER_MAX) w_timer_nxt = r_timer + TW'(1);
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_phase_nxt = '0;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_phase     <= '0;
      r_timer     <= '0;
      r_green_len <= GREEN_BASE;
      r_ext_used  <= 1'b0;
      r_flash     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_timer     <= w_timer_nxt;
      r_green_len <= w_green_len_nxt;
      r_ext_used  <= w_ext_used_nxt;
      r_flash     <= w_flash_nxt;
    end
  end

  // Lamp decode from the current state; registered, so lamps trail state by one clock
  assign w_sel = N_PHASES'(1) << r_phase;

  always_comb begin
    w_green_nxt  = '0;
    w_yellow_nxt = '0;
    w_red_nxt    = '1;
    case (r_state)
      S_GREEN: begin
        w_green_nxt = w_sel;
        w_red_nxt   = ~w_sel;
      end
      S_YELLOW: begin
        w_yellow_nxt = w_sel;
        w_red_nxt    = ~w_sel;
      end
      S_FLASH: begin
        w_yellow_nxt = {N_PHASES{r_flash}};
        w_red_nxt    = '0;
      end
      default: begin
        w_red_nxt = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_green  <= '0;
      r_yellow <= '0;
      r_red    <= '1;
    end else begin
      r_green  <= w_green_nxt;
      r_yellow <= w_yellow_nxt;
      r_red    <= w_red_nxt;
    end
  end

  assign green  = r_green;
  assign yellow = r_yellow;
  assign red    = r_red;
  assign phase  = r_phase;
  assign state  = r_state;

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: directed scenarios plus randomized run against a
// countdown-based behavioural model of the controller.
module tb_intersection_controller;

  localparam int N = 4;
  localparam int G = 30;
  localparam int E = 10;
  localparam int Y = 3;
  localparam int A = 2;
  localparam logic [2:0] ST_INIT = 3'd0, ST_GREEN = 3'd1, ST_YELLOW = 3'd2,
                         ST_ALLRED = 3'd3, ST_FLASH = 3'd4;
  localparam int M_INIT = 0, M_GREEN = 1, M_YELLOW = 2, M_ALLRED = 3, M_FLASH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic [3:0] demand = 4'hF;
  logic [3:0] ext_req = 4'h0;
  logic       force_red = 1'b0;
  logic       attention = 1'b0;
  logic [3:0] green, yellow, red;
  logic [1:0] phase;
  logic [2:0] state;

  int g_tests = 0;
  int g_fail  = 0;

  // Model: remaining ticks in the current interval rather than an elapsed counter
  int         m_state = M_INIT;
  int         m_phase = 0;
  int         m_left  = 0;
  bit         m_ext   = 1'b0;
  bit         m_flash = 1'b0;
  logic [3:0] m_g = 4'h0, m_y = 4'h0, m_r = 4'hF;

  intersection_controller dut (
    .clk(clk), .rst(rst), .tick(tick), .demand(demand), .ext_req(ext_req),
    .force_red(force_red), .attention(attention), .green(green), .yellow(yellow),
    .red(red), .phase(phase), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input int p);
    return 4'(1) << p;
  endfunction

  function automatic void model_step();
    logic [3:0] lg, ly, lr;
    int np;
    lg = 4'h0; ly = 4'h0; lr = 4'hF;
    if (m_state == M_GREEN) begin lg = oh(m_phase); lr = ~lg; end
    else if (m_state == M_YELLOW) begin ly = oh(m_phase); lr = ~ly; end
    else if (m_state == M_FLASH) begin lr = 4'h0; ly = m_flash ? 4'hF : 4'h0; end
    if (rst) begin
      m_state = M_INIT; m_phase = 0; m_ext = 1'b0; m_flash = 1'b0;
      m_g = 4'h0; m_y = 4'h0; m_r = 4'hF;
      return;
    end
    m_g = lg; m_y = ly; m_r = lr;
    case (m_state)
      M_INIT: begin m_state = M_GREEN; m_phase = 0; m_left = G; m_ext = 1'b0; end
      M_GREEN: begin
        if (force_red || attention) begin m_state = M_YELLOW; m_left = Y; end
        else if (tick && m_left == 1) begin m_state = M_YELLOW; m_left = Y; end
        else begin
          if (tick) m_left--;
          if (ext_req[2'(m_phase)] && !m_ext) begin m_left += E; m_ext = 1'b1; end
        end
      end
      M_YELLOW: if (tick) begin
        if (m_left == 1) begin m_state = M_ALLRED; m_left = A; end
        else m_left--;
      end
      M_ALLRED: begin
        if (force_red) m_left = A;
        else if (tick) begin
          if (m_left == 1) begin
            if (attention) begin m_state = M_FLASH; m_flash = 1'b1; end
            else begin
              np = (m_phase + 1) % N;
              for (int k = N; k >= 1; k--)
                if (demand[2'((m_phase + k) % N)]) np = (m_phase + k) % N;
              m_state = M_GREEN; m_phase = np; m_left = G; m_ext = 1'b0;
            end
          end else m_left--;
        end
      end
      default: begin
        if (force_red || !attention) begin m_state = M_ALLRED; m_left = A; end
        else if (tick) m_flash = ~m_flash;
      end
    endcase
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b1; force_red = 1'b0; attention = 1'b0; ext_req = 4'h0;
    tick_clk();
    tick_clk();
    rst = 1'b0;
  endtask

  task automatic measure_dwell(input logic [2:0] s, output int n);
    n = 0;
    while (state === s && n < 1000) begin
      tick_clk();
      n++;
    end
  endtask

  task automatic test_reset();
    demand = 4'hF;
    do_reset();
    g_tests++;
    if (state !== ST_INIT || phase !== 2'd0 || green !== 4'h0 || yellow !== 4'h0 || red !== 4'hF) begin
      g_fail++;
      $display("FAIL reset: state=%0d phase=%0d g=%b y=%b r=%b, want 0 0 0000 0000 1111",
               state, phase, green, yellow, red);
    end
    tick_clk();
    g_tests++;
    if (state !== ST_GREEN || phase !== 2'd0) begin
      g_fail++;
      $display("FAIL init_one_clock: state=%0d phase=%0d, want 1 0", state, phase);
    end
  endtask

  task automatic test_nominal();
    int n;
    demand = 4'hF;
    do_reset();
    tick_clk();
    for (int i = 0; i < 5; i++) begin
      g_tests++;
      if (phase !== 2'(i % N)) begin
        g_fail++; $display("FAIL nominal_phase%0d: got %0d want %0d", i, phase, i % N);
      end
      measure_dwell(ST_GREEN, n);
      g_tests++;
      if (n != G) begin g_fail++; $display("FAIL nominal_green%0d: got %0d want %0d", i, n, G); end
      g_tests++;
      if (green !== oh(i % N) || red !== ~oh(i % N) || yellow !== 4'h0) begin
        g_fail++;
        $display("FAIL nominal_lamp_lag%0d: g=%b y=%b r=%b want g=%b", i, green, yellow, red, oh(i % N));
      end
      measure_dwell(ST_YELLOW, n);
      g_tests++;
      if (n != Y) begin g_fail++; $display("FAIL nominal_yellow%0d: got %0d want %0d", i, n, Y); end
      measure_dwell(ST_ALLRED, n);
      g_tests++;
      if (n != A) begin g_fail++; $display("FAIL nominal_allred%0d: got %0d want %0d", i, n, A); end
    end
  endtask

  task automatic test_extension();
    int n;
    demand = 4'hF;
    do_reset();
    tick_clk();
    n = 0;
    while (state === ST_GREEN && n < 1000) begin
      ext_req = (n == 3 || n == 12) ? 4'b0001 : 4'b0000;
      tick_clk();
      n++;
    end
    ext_req = 4'h0;
    g_tests++;
    if (n != G + E) begin g_fail++; $display("FAIL ext_green: got %0d want %0d", n, G + E); end
    measure_dwell(ST_YELLOW, n);
    measure_dwell(ST_ALLRED, n);
    for (int i = 0; i < 3; i++) begin
      measure_dwell(ST_GREEN, n);
      measure_dwell(ST_YELLOW, n);
      measure_dwell(ST_ALLRED, n);
    end
    g_tests++;
    if (phase !== 2'd0 || state !== ST_GREEN) begin
      g_fail++; $display("FAIL ext_return: phase=%0d state=%0d want 0 1", phase, state);
    end
    measure_dwell(ST_GREEN, n);
    g_tests++;
    if (n != G) begin g_fail++; $display("FAIL ext_next_green: got %0d want %0d", n, G); end
  endtask

  task automatic test_demand();
    int n;
    demand = 4'b1000;
    do_reset();
    tick_clk();
    for (int i = 0; i < 2; i++) begin
      measure_dwell(ST_GREEN, n);
      measure_dwell(ST_YELLOW, n);
      measure_dwell(ST_ALLRED, n);
      g_tests++;
      if (phase !== 2'd3 || state !== ST_GREEN) begin
        g_fail++; $display("FAIL demand_skip%0d: phase=%0d state=%0d want 3 1", i, phase, state);
      end
    end
    demand = 4'hF;
  endtask

  task automatic test_force_red();
    int n, ycnt;
    logic [2:0] s1;
    demand = 4'hF;
    do_reset();
    tick_clk();
    repeat (10) tick_clk();
    force_red = 1'b1;
    ycnt = 0; s1 = ST_INIT;
    for (int k = 1; k <= 20; k++) begin
      tick_clk();
      if (k == 1) s1 = state;
      if (state === ST_YELLOW) ycnt++;
    end
    g_tests++;
    if (s1 !== ST_YELLOW) begin g_fail++; $display("FAIL force_yellow_next: got %0d want 2", s1); end
    g_tests++;
    if (ycnt != Y) begin g_fail++; $display("FAIL force_yellow_len: got %0d want %0d", ycnt, Y); end
    g_tests++;
    if (state !== ST_ALLRED || red !== 4'hF) begin
      g_fail++; $display("FAIL force_hold: state=%0d red=%b want 3 1111", state, red);
    end
    force_red = 1'b0;
    measure_dwell(ST_ALLRED, n);
    g_tests++;
    if (n != A) begin g_fail++; $display("FAIL force_release_allred: got %0d want %0d", n, A); end
    g_tests++;
    if (state !== ST_GREEN || phase !== 2'd1) begin
      g_fail++; $display("FAIL force_next_green: state=%0d phase=%0d want 1 1", state, phase);
    end
  endtask

  task automatic test_attention();
    int n;
    logic [3:0] exp_y;
    demand = 4'hF;
    do_reset();
    tick_clk();
    repeat (5) tick_clk();
    attention = 1'b1;
    tick_clk();
    g_tests++;
    if (state !== ST_YELLOW) begin g_fail++; $display("FAIL attn_yellow: got %0d want 2", state); end
    measure_dwell(ST_YELLOW, n);
    measure_dwell(ST_ALLRED, n);
    g_tests++;
    if (n != A || state !== ST_FLASH || phase !== 2'd0) begin
      g_fail++; $display("FAIL attn_flash_entry: allred=%0d state=%0d phase=%0d want 2 4 0", n, state, phase);
    end
    tick_clk();
    g_tests++;
    if (yellow !== 4'hF || green !== 4'h0 || red !== 4'h0) begin
      g_fail++; $display("FAIL attn_flash_start: g=%b y=%b r=%b want 0000 1111 0000", green, yellow, red);
    end
    for (int k = 0; k < 6; k++) begin
      tick_clk();
      exp_y = (k % 2 == 0) ? 4'h0 : 4'hF;
      g_tests++;
      if (yellow !== exp_y || red !== 4'h0) begin
        g_fail++; $display("FAIL attn_toggle%0d: y=%b r=%b want y=%b r=0000", k, yellow, red, exp_y);
      end
    end
    tick = 1'b0;
    repeat (2) begin
      tick_clk();
      g_tests++;
      if (yellow !== m_y) begin g_fail++; $display("FAIL attn_no_tick: y=%b want %b", yellow, m_y); end
    end
    tick = 1'b1;
    attention = 1'b0;
    tick_clk();
    g_tests++;
    if (state !== ST_ALLRED || phase !== 2'd0) begin
      g_fail++; $display("FAIL attn_exit: state=%0d phase=%0d want 3 0", state, phase);
    end
    measure_dwell(ST_ALLRED, n);
    g_tests++;
    if (n != A || state !== ST_GREEN || phase !== 2'd1) begin
      g_fail++; $display("FAIL attn_resume: allred=%0d state=%0d phase=%0d want 2 1 1", n, state, phase);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    demand = 4'hF;
    do_reset();
    tick_clk();
    n = 0;
    while (!(state === ST_YELLOW && phase === 2'd2) && n < 1000) begin tick_clk(); n++; end
    g_tests++;
    if (n >= 1000) begin g_fail++; $display("FAIL rstmid_reach: timeout got %0d want <1000", n); end
    tick_clk();
    rst = 1'b1;
    tick_clk();
    rst = 1'b0;
    g_tests++;
    if (red !== 4'hF || green !== 4'h0 || yellow !== 4'h0 || phase !== 2'd0 || state !== ST_INIT) begin
      g_fail++;
      $display("FAIL rstmid: state=%0d phase=%0d g=%b y=%b r=%b want 0 0 0000 0000 1111",
               state, phase, green, yellow, red);
    end
    tick_clk();
    g_tests++;
    if (state !== ST_GREEN || phase !== 2'd0) begin
      g_fail++; $display("FAIL rstmid_green: state=%0d phase=%0d want 1 0", state, phase);
    end
  endtask

  task automatic test_random();
    int prints = 0;
    demand = 4'hF;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) demand = 4'($urandom);
      ext_req = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 149) == 0) force_red = ~force_red;
      if ($urandom_range(0, 199) == 0) attention = ~attention;
      rst = ($urandom_range(0, 999) == 0);
      tick_clk();
      g_tests++;
      if (state !== 3'(m_state) || phase !== 2'(m_phase) ||
          green !== m_g || yellow !== m_y || red !== m_r) begin
        g_fail++;
        if (prints < 20) begin
          prints++;
          $display("FAIL random cyc%0d: state=%0d phase=%0d g=%b y=%b r=%b want state=%0d phase=%0d g=%b y=%b r=%b",
                   c, state, phase, green, yellow, red, m_state, m_phase, m_g, m_y, m_r);
        end
      end
    end
    rst = 1'b0; force_red = 1'b0; attention = 1'b0; ext_req = 4'h0; tick = 1'b1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_extension();
    test_demand();
    test_force_red();
    test_attention();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", g_tests, g_fail);
    $finish;
  end

endmodule
